// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with trap/MRET sequencing, prioritised
// interrupt arbitration, vectored mtvec and 64-bit mcycle/minstret counters.
module csr_unit #(
   parameter int unsigned NUM_EXT_IRQ = 4,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_8000,
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter bit          COUNTERS_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [1:0]             csr_op,
   input  logic [11:0]            csr_addr,
   input  logic [31:0]            csr_src,
   output logic [31:0]            csr_rdata,
   output logic                   csr_illegal,
   input  logic                   instr_retire,
   input  logic                   trap_take,
   input  logic [31:0]            trap_cause,
   input  logic [31:0]            trap_pc,
   input  logic                   mret,
   input  logic                   irq_sw,
   input  logic                   irq_timer,
   input  logic                   irq_ext_m,
   input  logic [NUM_EXT_IRQ-1:0] irq_plat,
   output logic                   irq_req,
   output logic [31:0]            irq_cause,
   output logic [31:0]            trap_vector,
   output logic [31:0]            mepc_out
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSTATUSH  = 12'h310;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;  // MXL=32, I extension
   localparam logic [31:0] PLAT_MASK = ((32'd1 << NUM_EXT_IRQ) - 32'd1) << 16;
   localparam logic [31:0] MIE_MASK  = 32'h0000_0888 | PLAT_MASK;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;

   logic        mst_mie_q, mst_mie_d;
   logic        mst_mpie_q, mst_mpie_d;
   logic [29:0] mtvec_base_q, mtvec_base_d;
   logic        mtvec_mode_q, mtvec_mode_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mip_q, mip_d;
   logic [29:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [63:0] mcycle_q, minstret_q;

   logic [31:0] rdata, wdata;
   logic        hit, wr_req, wr_en;
   logic [31:0] pending;
   logic [4:0]  irq_code;

   // Read mux; also flags whether the address is implemented
   always_comb begin
      rdata = '0;
      hit   = 1'b1;
      case (csr_addr)
         A_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
         A_MSTATUSH:  rdata = '0;
         A_MISA:      rdata = MISA_VAL;
         A_MHARTID:   rdata = HART_ID;
         A_MTVEC:     rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
         A_MIE:       rdata = mie_q;
         A_MIP:       rdata = mip_q;
         A_MEPC:      rdata = {mepc_q, 2'b00};
         A_MCAUSE:    rdata = mcause_q;
         A_MSCRATCH:  rdata = mscratch_q;
         A_MCYCLE:    rdata = mcycle_q[31:0];
         A_MCYCLEH:   rdata = mcycle_q[63:32];
         A_MINSTRET:  rdata = minstret_q[31:0];
         A_MINSTRETH: rdata = minstret_q[63:32];
         default:     hit   = 1'b0;
      endcase
   end

   assign csr_rdata = rdata;

   // RS/RC with a zero mask are pure reads, so they are legal on read-only CSRs
   assign wr_req      = (csr_op == OP_RW) || ((csr_op != OP_NONE) && (csr_src != '0));
   assign csr_illegal = (csr_op != OP_NONE) &&
                        (!hit || ((csr_addr[11:10] == 2'b11) && wr_req));
   assign wr_en       = wr_req && !csr_illegal;

   // Read-modify-write value
   always_comb begin
      case (csr_op)
         OP_RW:   wdata = csr_src;
         OP_RS:   wdata = rdata | csr_src;
         default: wdata = rdata & ~csr_src;
      endcase
   end

   // Next state for non-counter CSRs; later assignments win: trap > mret > CSR write
   always_comb begin
      mst_mie_d    = mst_mie_q;
      mst_mpie_d   = mst_mpie_q;
      mtvec_base_d = mtvec_base_q;
      mtvec_mode_d = mtvec_mode_q;
      mie_d        = mie_q;
      mepc_d       = mepc_q;
      mcause_d     = mcause_q;
      mscratch_d   = mscratch_q;
      if (wr_en) begin
         case (csr_addr)
            A_MSTATUS: begin
               mst_mie_d  = wdata[3];
               mst_mpie_d = wdata[7];
            end
            A_MTVEC: begin
               mtvec_base_d = wdata[31:2];
               if (wdata[1:0] < 2'd2) mtvec_mode_d = wdata[0];
            end
            A_MIE:      mie_d      = wdata & MIE_MASK;
            A_MEPC:     mepc_d     = wdata[31:2];
            A_MCAUSE:   mcause_d   = wdata;
            A_MSCRATCH: mscratch_d = wdata;
            default: ;
         endcase
      end
      if (mret) begin
         mst_mie_d  = mst_mpie_q;
         mst_mpie_d = 1'b1;
      end
      if (trap_take) begin
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
         mepc_d     = trap_pc[31:2];
         mcause_d   = trap_cause;
      end
   end

   // Interrupt sources land in their mip bit positions, registered once
   always_comb begin
      mip_d = '0;
      mip_d[3]  = irq_sw;
      mip_d[7]  = irq_timer;
      mip_d[11] = irq_ext_m;
      mip_d[16 +: NUM_EXT_IRQ] = irq_plat;
   end

   // CSR state registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mst_mie_q    <= 1'b0;
         mst_mpie_q   <= 1'b0;
         mtvec_base_q <= RESET_MTVEC[31:2];
         mtvec_mode_q <= RESET_MTVEC[0];
         mie_q        <= '0;
         mip_q        <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mscratch_q   <= '0;
      end else begin
         mst_mie_q    <= mst_mie_d;
         mst_mpie_q   <= mst_mpie_d;
         mtvec_base_q <= mtvec_base_d;
         mtvec_mode_q <= mtvec_mode_d;
         mie_q        <= mie_d;
         mip_q        <= mip_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         mscratch_q   <= mscratch_d;
      end
   end

   // Counters: a CSR write replaces one half and suppresses that cycle's increment
   if (COUNTERS_EN) begin : g_cnt
      logic [63:0] mcycle_d, minstret_d;

      // Counter next state
      always_comb begin
         mcycle_d   = mcycle_q + 64'd1;
         minstret_d = instr_retire ? minstret_q + 64'd1 : minstret_q;
         if (wr_en) begin
            case (csr_addr)
               A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
               A_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
               A_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
               A_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
               default: ;
            endcase
         end
      end

      // Counter registers
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
         end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
         end
      end
   end else begin : g_nocnt
      assign mcycle_q   = '0;
      assign minstret_q = '0;
   end

   assign pending = mip_q & mie_q;

   // Priority pick: MEI > MSI > MTI > plat[0] > plat[1] > ...
   always_comb begin
      irq_code = '0;
      for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
         if (pending[16 + i]) irq_code = 5'(16 + i);
      if (pending[7])  irq_code = 5'd7;
      if (pending[3])  irq_code = 5'd3;
      if (pending[11]) irq_code = 5'd11;
   end

   assign irq_req   = mst_mie_q && (pending != '0);
   assign irq_cause = irq_req ? {1'b1, 26'b0, irq_code} : 32'd0;

   // Vectored mode only offsets for interrupts; exceptions go to the base
   assign trap_vector = (mtvec_mode_q && trap_cause[31]) ?
                        {mtvec_base_q, 2'b00} + {trap_cause[29:0], 2'b00} :
                        {mtvec_base_q, 2'b00};
   assign mepc_out    = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
module tb_csr_unit;

  localparam int unsigned NEXT = 4;

  logic            clk, nrst;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_src, csr_rdata;
  logic            csr_illegal;
  logic            instr_retire, trap_take, mret;
  logic [31:0]     trap_cause, trap_pc;
  logic            irq_sw, irq_timer, irq_ext_m;
  logic [NEXT-1:0] irq_plat;
  logic            irq_req;
  logic [31:0]     irq_cause, trap_vector, mepc_out;

  int n_tests = 0;
  int n_fail  = 0;

  csr_unit #(.NUM_EXT_IRQ(NEXT)) dut (
    .clk(clk), .nrst(nrst),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_src(csr_src),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire), .trap_take(trap_take),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext_m(irq_ext_m),
    .irq_plat(irq_plat), .irq_req(irq_req), .irq_cause(irq_cause),
    .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a CSR with no operation in flight
  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_op = 2'b00; csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  // One CSR op cycle without checks
  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src);
    csr_op = op; csr_addr = addr; csr_src = src;
    tick();
    csr_op = 2'b00;
  endtask

  // One CSR op cycle, checking old value and illegal flag
  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                     input logic [31:0] exp_rd, input logic exp_ill, input string tag);
    csr_op = op; csr_addr = addr; csr_src = src;
    #1;
    chk({tag, ".rd"}, csr_rdata, exp_rd);
    chk({tag, ".ill"}, {31'b0, csr_illegal}, {31'b0, exp_ill});
    tick();
    csr_op = 2'b00;
  endtask

  initial begin
    nrst = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_src = '0;
    instr_retire = 1'b0; trap_take = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0;
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext_m = 1'b0; irq_plat = '0;
    repeat (2) tick();
    nrst = 1'b1;
    #1;

    // Reset state
    chk("rst.irq_req", {31'b0, irq_req}, 32'd0);
    chk("rst.irq_cause", irq_cause, 32'd0);
    chk("rst.mepc_out", mepc_out, 32'd0);
    chk("rst.trap_vector", trap_vector, 32'h0000_8000);
    rd(12'h305, 32'h0000_8000, "rst.mtvec");
    rd(12'h300, 32'h0000_1800, "rst.mstatus");
    rd(12'h301, 32'h4000_0100, "misa");

    // mie set/clear and write mask
    csr(2'b10, 12'h304, 32'h888, 32'h0, 1'b0, "mie.rs");
    csr(2'b11, 12'h304, 32'h8, 32'h888, 1'b0, "mie.rc");
    rd(12'h304, 32'h880, "mie.after_rc");
    csr(2'b01, 12'h304, 32'hFFFF_FFFF, 32'h880, 1'b0, "mie.rw_all");
    rd(12'h304, 32'h000F_0888, "mie.mask");

    // Read-only / unimplemented access legality
    csr(2'b10, 12'hF14, 32'h0, 32'h0, 1'b0, "mhartid.rs0");
    csr(2'b01, 12'hF14, 32'h5, 32'h0, 1'b1, "mhartid.rw");
    rd(12'hF14, 32'h0, "mhartid.unchanged");
    csr(2'b10, 12'h7C0, 32'h1, 32'h0, 1'b1, "unimpl");
    csr(2'b01, 12'h340, 32'hA5A5_0001, 32'h0, 1'b0, "mscratch.rw");
    rd(12'h340, 32'hA5A5_0001, "mscratch");

    // Interrupt arbitration
    wr(2'b01, 12'h304, 32'h888);
    wr(2'b01, 12'h300, 32'h8);
    irq_timer = 1'b1; irq_ext_m = 1'b1;
    #1;
    chk("irq.latency", {31'b0, irq_req}, 32'd0);
    tick();
    chk("irq.req", {31'b0, irq_req}, 32'd1);
    chk("irq.cause_mei", irq_cause, 32'h8000_000B);
    rd(12'h344, 32'h880, "mip");
    irq_ext_m = 1'b0;
    tick();
    chk("irq.cause_mti", irq_cause, 32'h8000_0007);
    irq_timer = 1'b0; irq_plat = 4'b0110;
    csr(2'b01, 12'h304, 32'h0006_0000, 32'h888, 1'b0, "mie.plat");
    chk("irq.cause_plat", irq_cause, 32'h8000_0011);
    irq_plat = '0;
    tick();
    chk("irq.none", {31'b0, irq_req}, 32'd0);
    chk("irq.cause_none", irq_cause, 32'd0);

    // mtvec modes
    wr(2'b01, 12'h305, 32'h1001);
    trap_cause = 32'h8000_0007;
    #1;
    chk("tvec.vectored", trap_vector, 32'h101C);
    trap_cause = 32'h2;
    #1;
    chk("tvec.sync", trap_vector, 32'h1000);
    wr(2'b01, 12'h305, 32'h2003);
    rd(12'h305, 32'h2001, "tvec.keep_mode");

    // mepc low bits
    wr(2'b01, 12'h341, 32'h1234_5677);
    rd(12'h341, 32'h1234_5674, "mepc.align");

    // Trap coincident with mstatus write, then mret
    trap_take = 1'b1; trap_pc = 32'h402; trap_cause = 32'h8000_000B;
    csr(2'b01, 12'h300, 32'h8, 32'h1808, 1'b0, "trap.mstatus");
    trap_take = 1'b0;
    chk("trap.mepc_out", mepc_out, 32'h400);
    rd(12'h300, 32'h1880, "trap.mstatus_after");
    rd(12'h342, 32'h8000_000B, "trap.mcause");
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd(12'h300, 32'h1888, "mret.mstatus");

    // mcycle carry across halves
    wr(2'b01, 12'hB80, 32'h0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle.preset");
    tick();
    rd(12'hB80, 32'h1, "mcycleh.carry");
    rd(12'hB00, 32'h0, "mcycle.wrap");

    // minstret write wins over retire
    instr_retire = 1'b1;
    wr(2'b01, 12'hB02, 32'h55);
    instr_retire = 1'b0;
    rd(12'hB02, 32'h55, "minstret.wr");
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    rd(12'hB02, 32'h56, "minstret.inc");

    // Reset mid-run
    irq_timer = 1'b1;
    wr(2'b01, 12'h304, 32'h80);
    nrst = 1'b0;
    #1;
    chk("mrst.irq_req", {31'b0, irq_req}, 32'd0);
    chk("mrst.mepc_out", mepc_out, 32'd0);
    rd(12'hB00, 32'h0, "mrst.mcycle");
    rd(12'hB82, 32'h0, "mrst.minstreth");
    rd(12'hB02, 32'h0, "mrst.minstret");
    rd(12'h305, 32'h8000, "mrst.mtvec");
    rd(12'h304, 32'h0, "mrst.mie");
    rd(12'h300, 32'h1800, "mrst.mstatus");
    irq_timer = 1'b0;
    tick();
    nrst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised machine-mode CSR file, successor to the single-hart M-mode CSR block.
- Performs CSRRW/CSRRS/CSRRC read-modify-write internally.
- Adds trap entry and MRET return sequencing, prioritised interrupt arbitration over standard and platform lines, vectored mtvec, and 64-bit mcycle/minstret counters.
- Sits beside the decode/execute stage; the core drives trap/mret strobes and consumes the vector, return PC and interrupt request.

Parameters:
NUM_EXT_IRQ, 4, platform interrupt lines mapped to mip/mie bits 16..16+NUM_EXT_IRQ-1 (1..16)
RESET_MTVEC, 32'h0000_8000, mtvec reset value (direct mode)
HART_ID, 0, value returned by mhartid
COUNTERS_EN, 1, 0 removes mcycle/minstret (reads return 0, writes ignored)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
csr_addr  in  12  CSR address
csr_src  in  32  rs1 value or zero-extended uimm
csr_rdata  out  32  old CSR value (combinational)
csr_illegal  out  1  access is illegal (combinational)
instr_retire  in  1  one instruction retired this cycle
trap_take  in  1  core enters trap this cycle
trap_cause  in  32  mcause value to record
trap_pc  in  32  PC to record in mepc
mret  in  1  MRET executing this cycle
irq_sw, irq_timer, irq_ext_m  in  1 each  MSIP, MTIP, MEIP sources
irq_plat  in  NUM_EXT_IRQ  platform interrupt lines
irq_req  out  1  enabled interrupt pending
irq_cause  out  32  cause of highest-priority pending interrupt
trap_vector  out  32  handler address for trap_cause
mepc_out  out  32  MRET return address

Behaviour:
- Clock/reset: one clock; reset asynchronous, active-low. Reset: mstatus=0, mtvec=RESET_MTVEC, mie=0, mip latch=0, mepc=0, mcause=0, mscratch=0, counters=0. Outputs at reset: irq_req=0, irq_cause=0, mepc_out=0, trap_vector=RESET_MTVEC.
- Implemented CSRs: mstatus, mstatush (read 0), misa (read-only RV32I), mhartid (read-only), mtvec, mie, mip, mepc, mcause, mscratch, mcycle/h, minstret/h.
- mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; other bits read 0.
- mtvec: writes with mode>=2 keep the previous mode, base still updates.
- mepc: bits[1:0] always 0.
- mie: writable only at bits 3, 7, 11 and the platform bits.
- Write value: RW=src; RS=old|src; RC=old&~src. RS/RC with src==0 perform no write. Writes commit at the clock edge; csr_rdata always shows the pre-write value.
- csr_illegal=1 when op!=0 and any of:
  - address unimplemented;
  - address[11:10]==2'b11 and a write would occur.
  An illegal access changes no state.
- mip: each source is registered once (1-cycle latency), read-only; CSR writes to mip are ignored.
- pending = mip & mie. irq_req = mstatus.MIE & |pending.
- Priority: MEI(11) > MSI(3) > MTI(7) > irq_plat[0] > irq_plat[1] > ... irq_cause = {1'b1, 31'(code)}; irq_cause=0 when irq_req=0.
- trap_vector: direct mode = {base,2'b00}. Vectored mode with trap_cause[31]=1 adds 4*trap_cause[30:0]; synchronous causes use base only.
- trap_take, next edge: mepc=trap_pc&~3, mcause=trap_cause, MPIE=MIE, MIE=0.
- mret, next edge: MIE=MPIE, MPIE=1.
- Precedence in the same cycle: trap_take > mret > CSR write for any overlapping field. Non-overlapping CSR writes still commit.
- mcycle increments every cycle. minstret increments on instr_retire. Both are 64-bit and wrap from all-ones to 0. A CSR write to either half replaces that half and suppresses that counter's increment in that cycle; the carry across halves is handled as one 64-bit add.

Test Plan:
- Reset mid-run with counters nonzero -> all CSRs at reset values, mtvec reads 32'h8000, irq_req=0.
- CSRRS mie src=32'h888, then CSRRC src=32'h8 -> rdata 0 then 32'h888; final mie=32'h880. CSRRS with src=0 on mhartid -> csr_illegal=0, no write.
- mstatus.MIE=1, mie=32'h888, irq_timer and irq_ext_m asserted together -> irq_req one cycle later, irq_cause=32'h8000000B. Drop MEIP -> irq_cause=32'h80000007.
- mtvec write 32'h1001 (vectored), trap_cause 32'h80000007 -> trap_vector=32'h101C. trap_cause=2 -> 32'h1000. mtvec write 32'h2003 -> reads 32'h2001.
- trap_take with pc=32'h402, coincident with a CSRRW mstatus=8 -> mepc=32'h400, MIE=0, MPIE=old MIE. A following mret restores MIE.
- mcycle preset to 32'hFFFFFFFF with mcycleh=0 -> next cycle mcycleh=1, mcycle=0. A write to minstret in the same cycle as instr_retire -> the written value is held without increment.
